// File: rtl/mem_wb_stage.sv
// Memory / write-back pipeline stage: data memory with a registered read,
// fault detection on LW/SW, register-file write-back and retire counters.
module mem_wb_stage #(
    parameter int RFW = 5,
    parameter int DMW = 6,
    parameter int DW  = 32,
    parameter int IW  = 32
) (
    input  logic           clk,
    input  logic           start,
    input  logic           in_valid,
    input  logic [IW-1:0]  in_inst,
    input  logic [DW-1:0]  in_alu,
    input  logic [DW-1:0]  in_store,
    output logic           wb_we,
    output logic [RFW-1:0] wb_addr,
    output logic [DW-1:0]  wb_data,
    output logic [IW-1:0]  out_inst,
    output logic           out_valid,
    output logic           err,
    output logic [15:0]    load_cnt,
    output logic [15:0]    store_cnt
);

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] OP_J   = 6'h02;

    logic [5:0]     opcode;
    logic [4:0]     rd;
    logic [DMW-1:0] idx;
    logic           is_lw, is_sw, is_nop, no_wb_op;
    logic           addr_hi, fault, mem_we;

    logic [DW-1:0]  mem_q [2**DMW];

    logic           wb_we_q, wb_we_d;
    logic [RFW-1:0] wb_addr_q, wb_addr_d;
    logic [DW-1:0]  wb_data_q, wb_data_d;
    logic [IW-1:0]  out_inst_q, out_inst_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q, err_d;
    logic [15:0]    load_cnt_q, load_cnt_d;
    logic [15:0]    store_cnt_q, store_cnt_d;

    assign opcode   = in_inst[31:26];
    assign rd       = in_inst[25:21];
    assign idx      = in_alu[DMW+1:2];
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_nop   = (in_inst == '0);
    assign no_wb_op = is_sw || (opcode == OP_BEQ) || (opcode == OP_BNE) || (opcode == OP_J);
    assign addr_hi  = ((in_alu >> (DMW + 2)) != '0);
    assign fault    = (is_lw || is_sw) && ((in_alu[1:0] != 2'b00) || addr_hi);
    // start has priority: an SW in the reset cycle must not touch memory
    assign mem_we   = in_valid && is_sw && !fault && !start;

    always_comb begin
        wb_we_d     = in_valid && !no_wb_op && !is_nop && (rd != 5'd0) && !fault;
        wb_addr_d   = RFW'(rd);
        wb_data_d   = is_lw ? mem_q[idx] : in_alu;
        out_inst_d  = in_valid ? in_inst : '0;
        out_valid_d = in_valid;
        err_d       = err_q || (in_valid && fault);
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        if (in_valid && !fault && is_lw) begin
            load_cnt_d = load_cnt_q + 16'd1;
        end
        if (in_valid && !fault && is_sw) begin
            store_cnt_d = store_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            wb_we_q     <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            out_inst_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            wb_we_q     <= wb_we_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
            out_inst_q  <= out_inst_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    // Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= in_store;
        end
    end

    assign wb_we     = wb_we_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign out_inst  = out_inst_q;
    assign out_valid = out_valid_q;
    assign err       = err_q;
    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a word-array reference model.
module tb_mem_wb_stage;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        start, in_valid;
    logic [31:0] in_inst, in_alu, in_store;
    logic        wb_we, out_valid, err;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data, out_inst;
    logic [15:0] load_cnt, store_cnt;

    mem_wb_stage dut (
        .clk(clk), .start(start), .in_valid(in_valid), .in_inst(in_inst),
        .in_alu(in_alu), .in_store(in_store), .wb_we(wb_we), .wb_addr(wb_addr),
        .wb_data(wb_data), .out_inst(out_inst), .out_valid(out_valid), .err(err),
        .load_cnt(load_cnt), .store_cnt(store_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [DEPTH];
    int          ref_lc, ref_sc;
    logic        ref_err;
    logic        exp_we, exp_valid;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data, exp_inst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd);
        return {op, rd, 21'h0_1234};
    endfunction

    // One clock: apply inputs, advance the model, compare the registered outputs.
    task automatic step(input logic s, input logic v, input logic [31:0] inst,
                        input logic [31:0] alu, input logic [31:0] st);
        logic [5:0] op;
        logic       lw, sw, flt;
        int         w;
        start = s; in_valid = v; in_inst = inst; in_alu = alu; in_store = st;
        op  = inst[31:26];
        lw  = (op == 6'h23);
        sw  = (op == 6'h2B);
        flt = (lw || sw) && ((alu % 4) != 0 || alu >= 32'(DEPTH * 4));
        w   = int'((alu / 4) % DEPTH);
        if (s) begin
            exp_we = 0; exp_valid = 0; exp_addr = 0; exp_data = 0; exp_inst = 0;
            ref_err = 0; ref_lc = 0; ref_sc = 0;
        end else begin
            exp_valid = v;
            exp_inst  = inst;
            exp_addr  = inst[25:21];
            exp_we    = v && !(sw || op == 6'h04 || op == 6'h05 || op == 6'h02)
                        && inst != 0 && inst[25:21] != 0 && !flt;
            exp_data  = lw ? ref_mem[w] : alu;
            if (v && flt) ref_err = 1;
            if (v && !flt && lw) ref_lc = (ref_lc + 1) % 65536;
            if (v && !flt && sw) begin
                ref_sc = (ref_sc + 1) % 65536;
                ref_mem[w] = st;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("wb_we", 32'(wb_we), 32'(exp_we));
        check("err", 32'(err), 32'(ref_err));
        check("load_cnt", 32'(load_cnt), 32'(ref_lc));
        check("store_cnt", 32'(store_cnt), 32'(ref_sc));
        if (exp_we || s) begin
            check("wb_addr", 32'(wb_addr), 32'(exp_addr));
            check("wb_data", wb_data, exp_data);
        end
        if (exp_valid || s) check("out_inst", out_inst, exp_inst);
    endtask

    task automatic bubble();
        step(0, 0, 32'($urandom), 32'($urandom), 32'($urandom));
    endtask

    initial begin
        logic [31:0] inst, alu, old0;
        logic [4:0]  rd;
        int          k;
        start = 1; in_valid = 0; in_inst = 0; in_alu = 0; in_store = 0;
        @(posedge clk);
        #1;
        step(1, 1, mk(6'h2B, 5'd1), 32'h20, 32'h5555_AAAA);
        step(1, 0, 0, 0, 0);

        // store then load of the same word on the next cycle
        step(0, 1, mk(6'h2B, 5'd9), 32'h10, 32'hDEADBEEF);
        step(0, 1, mk(6'h23, 5'd3), 32'h10, 32'h0);
        check("rd3_we", 32'(wb_we), 32'd1);
        check("rd3_addr", 32'(wb_addr), 32'd3);
        check("rd3_data", wb_data, 32'hDEADBEEF);
        check("rd3_lc", 32'(load_cnt), 32'd1);
        check("rd3_sc", 32'(store_cnt), 32'd1);

        for (int i = 0; i < DEPTH; i++)
            step(0, 1, mk(6'h2B, 5'd0), 32'(i * 4), 32'($urandom));

        step(0, 1, mk(6'h08, 5'd7), 32'h1234, 0);
        check("alu7_data", wb_data, 32'h1234);
        check("alu7_addr", 32'(wb_addr), 32'd7);
        step(0, 1, mk(6'h08, 5'd0), 32'h1234, 0);
        check("alu0_we", 32'(wb_we), 32'd0);
        check("alu0_valid", 32'(out_valid), 32'd1);

        step(0, 1, mk(6'h23, 5'd4), 32'h13, 0);
        check("misalign_err", 32'(err), 32'd1);
        for (int i = 0; i < 10; i++) bubble();
        check("err_sticky", 32'(err), 32'd1);

        // out-of-range store must leave word 0 alone
        step(1, 0, 0, 0, 0);
        old0 = ref_mem[0];
        step(0, 1, mk(6'h2B, 5'd0), 32'h100, 32'hCAFE_F00D);
        check("oor_err", 32'(err), 32'd1);
        step(0, 1, mk(6'h23, 5'd2), 32'h0, 0);
        check("oor_word0", wb_data, old0);

        step(0, 1, mk(6'h2B, 5'd0), 32'h8, 32'h1111_2222);
        check("seq0", 32'(out_valid), 32'd1);
        step(0, 1, mk(6'h23, 5'd5), 32'h8, 0);
        check("seq1", 32'(out_valid), 32'd1);
        step(0, 1, 32'h0, 32'h44, 0);
        check("seq2", 32'(out_valid), 32'd1);
        check("nop_we", 32'(wb_we), 32'd0);
        bubble();
        check("seq3", 32'(out_valid), 32'd0);
        step(0, 1, mk(6'h00, 5'd6), 32'h77, 0);
        check("seq4", 32'(out_valid), 32'd1);

        // store during reset is discarded
        old0 = ref_mem[5];
        step(1, 1, mk(6'h2B, 5'd0), 32'h14, ~old0);
        check("rst_valid", 32'(out_valid), 32'd0);
        step(0, 1, mk(6'h23, 5'd1), 32'h14, 0);
        check("rst_sw_data", wb_data, old0);

        for (int i = 0; i < 2000; i++) begin
            k  = int'($urandom_range(0, 7));
            rd = 5'($urandom);
            case (k)
                0: inst = {6'h23, rd, 21'($urandom)};
                1: inst = {6'h2B, rd, 21'($urandom)};
                2: inst = {6'h04, rd, 21'($urandom)};
                3: inst = {6'h05, rd, 21'($urandom)};
                4: inst = {6'h02, rd, 21'($urandom)};
                5: inst = 32'h0;
                default: inst = {6'h00, rd, 21'($urandom) | 21'h1};
            endcase
            alu = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, DEPTH - 1) * 4) : 32'($urandom);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, inst, alu, 32'($urandom));
        end

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 65536; i++)
            step(0, 1, mk(6'h23, 5'd1), 32'($urandom_range(0, DEPTH - 1) * 4), 0);
        check("lc_wrap", 32'(load_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
